// File: rtl/xuart_tx_if.sv
// Parallel register port between the core's external
// interface and the UART transmitter.
interface xuart_tx_if #(
  parameter int PAR_ADDR_W = 12,
  parameter int DATA_W     = 32
);
  logic [PAR_ADDR_W-1:0] par_addr;
  logic                  par_re;
  logic                  par_we;
  logic [DATA_W-1:0]     par_out;
  logic [DATA_W-1:0]     par_in;

  modport master (
    output par_addr, par_re, par_we, par_out,
    input  par_in
  );

  modport slave (
    input  par_addr, par_re, par_we, par_out,
    output par_in
  );
endinterface

// File: rtl/xuart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO
// and a programmable per-bit clock divisor.
module xuart_tx #(
  parameter int          DATA_W     = 32,
  parameter int          PAR_ADDR_W = 12,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RST    = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  xuart_tx_if.slave   bus,
  output logic        tx
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ?
                         $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic [15:0]      div_q;
  logic [7:0]       shreg_q;
  logic [2:0]       bit_q;
  logic [15:0]      baud_q;

  logic [1:0]  reg_sel;
  logic        wr_data, wr_stat, wr_div;
  logic        empty, full, busy;
  logic        push_ok, pop;
  logic        load, shift, tick;
  logic [15:0] div_eff;
  logic [2:0]  cnt3;
  logic        unused_ok;

  assign reg_sel = bus.par_addr[1:0];
  assign wr_data = bus.par_we & (reg_sel == 2'd0);
  assign wr_stat = bus.par_we & (reg_sel == 2'd1);
  assign wr_div  = bus.par_we & (reg_sel == 2'd2);

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign busy  = (state_q != IDLE) | ~empty;

  // A full FIFO still takes a byte when the FSM pops it
  // in the same cycle.
  assign push_ok = wr_data & (~full | pop);

  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
  assign tick    = (baud_q == 16'd0);
  assign cnt3    = 3'(count_q);

  assign unused_ok = ^{bus.par_re,
                       bus.par_addr[PAR_ADDR_W-1:2],
                       bus.par_out[DATA_W-1:16]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, FIFO pop, bit timing controls and line level.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    tx      = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (tick) begin
          load    = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        tx = shreg_q[0];
        if (tick) begin
          load  = 1'b1;
          shift = 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register, bit index and baud counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
    end else begin
      if (pop)        shreg_q <= mem_q[rd_ptr_q];
      else if (shift) shreg_q <= shreg_q >> 1;
      if (pop)        bit_q <= '0;
      else if (shift) bit_q <= bit_q + 3'd1;
      if (load)       baud_q <= div_eff - 16'd1;
      else if (!tick) baud_q <= baud_q - 16'd1;
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.par_out[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)
        count_q <= count_q + 1'b1;
      else if (!push_ok && pop)
        count_q <= count_q - 1'b1;
      if (wr_stat)
        ovf_q <= 1'b0;
      else if (wr_data && full && !pop)
        ovf_q <= 1'b1;
    end
  end

  // Divisor register.
  always_ff @(posedge clk) begin
    if (rst)         div_q <= DIV_RST;
    else if (wr_div) div_q <= bus.par_out[15:0];
  end

  // Combinational register read-back.
  always_comb begin
    bus.par_in = '0;
    unique case (1'b1)
      (reg_sel == 2'd1):
        bus.par_in[6:0] = {cnt3, ovf_q, empty, full, busy};
      (reg_sel == 2'd2):
        bus.par_in[15:0] = div_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xuart_tx.sv
// Randomised self-checking bench for xuart_tx against a
// waveform-level model of the transmitter.
module tb_xuart_tx;

  logic clk = 1'b0;
  logic rst;
  logic tx;

  xuart_tx_if #(.PAR_ADDR_W(12), .DATA_W(32)) bus ();

  xuart_tx #(
    .DATA_W(32),
    .PAR_ADDR_W(12),
    .FIFO_DEPTH(4),
    .DIV_RST(16'd868)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx(tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h t=%0t",
                  nm, act, exp, $time);
  endtask

  // Model: FIFO contents as a byte queue, the frame in flight
  // as a per-cycle queue of line levels.
  byte unsigned fq[$];
  bit           txq[$];
  bit           m_ovf;
  logic [15:0]  m_div;
  bit           mvalid = 1'b0;

  function automatic bit m_busy();
    return (txq.size() != 0) || (fq.size() != 0);
  endfunction

  function automatic logic [31:0] m_status();
    return {25'd0, 3'(fq.size()), m_ovf,
            fq.size() == 0, fq.size() == 4, m_busy()};
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    logic [1:0] s;
    s = a[1:0];
    if (s == 2'd1) return m_status();
    if (s == 2'd2) return {16'd0, m_div};
    return 32'd0;
  endfunction

  task automatic model_step();
    bit          p;
    int          d;
    byte unsigned b;
    bit          v;
    if (rst) begin
      fq.delete();
      txq.delete();
      m_ovf  = 1'b0;
      m_div  = 16'd868;
      mvalid = 1'b1;
      return;
    end
    if (!mvalid) return;
    p = (txq.size() == 0) && (fq.size() > 0);
    d = (m_div == 16'd0) ? 1 : int'(m_div);
    if (txq.size() > 0) void'(txq.pop_front());
    if (p) begin
      b = fq.pop_front();
      for (int k = 0; k < 10; k++) begin
        if (k == 0)      v = 1'b0;
        else if (k == 9) v = 1'b1;
        else             v = b[k-1];
        repeat (d) txq.push_back(v);
      end
    end
    if (bus.par_we) begin
      case (bus.par_addr[1:0])
        2'd0: begin
          if (fq.size() < 4) fq.push_back(bus.par_out[7:0]);
          else m_ovf = 1'b1;
        end
        2'd1: m_ovf = 1'b0;
        2'd2: m_div = bus.par_out[15:0];
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of line and read-back.
  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      chk("tx", {31'd0, tx},
          {31'd0, (txq.size() != 0) ? txq[0] : 1'b1});
      chk("par_in", bus.par_in, m_read(bus.par_addr));
    end
  end

  bit logon = 1'b0;
  bit txlog[$];

  initial forever begin
    @(negedge clk);
    if (logon) txlog.push_back(tx);
  end

  task automatic drive(logic [11:0] a, logic we, logic re,
                       logic [31:0] d);
    bus.par_addr = a;
    bus.par_we   = we;
    bus.par_re   = re;
    bus.par_out  = d;
  endtask

  task automatic cyc(logic [11:0] a, logic we,
                     logic [31:0] d);
    drive(a, we, 1'b0, d);
    @(posedge clk);
    #1;
    drive(12'd1, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(logic [11:0] a, output logic [31:0] v);
    drive(a, 1'b0, 1'b1, 32'd0);
    #1;
    v = bus.par_in;
    bus.par_re = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(string nm, int lim);
    logic [31:0] s;
    int n;
    n = 0;
    rd(12'd1, s);
    while (s[0] && n < lim) begin
      idle(1);
      rd(12'd1, s);
      n++;
    end
    chk(nm, {31'd0, s[0]}, 32'd0);
  endtask

  function automatic int find0(int from);
    for (int i = from; i < txlog.size(); i++)
      if (!txlog[i]) return i;
    return -1;
  endfunction

  logic [31:0] v;
  logic [7:0]  pat;
  logic [7:0]  exp_b [5];
  logic        e;
  int          j, pj;
  int          r;

  initial begin
    rst = 1'b1;
    drive(12'd1, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(12'd1, v); chk("rst_status", v, 32'h04);
    rd(12'd2, v); chk("rst_div", v, 32'd868);
    chk("rst_tx", {31'd0, tx}, 32'd1);

    // DIV=4, one 0x55 frame.
    cyc(12'd2, 1'b1, 32'd4);
    cyc(12'd0, 1'b1, 32'h55);
    rd(12'd1, v); chk("w55_status", v, 32'h11);
    chk("w55_tx0", {31'd0, tx}, 32'd1);
    pat = 8'h55;
    for (int k = 1; k <= 41; k++) begin
      idle(1);
      if (k <= 4)       e = 1'b0;
      else if (k <= 36) e = pat[(k-5)/4];
      else              e = 1'b1;
      chk($sformatf("w55_tx%0d", k), {31'd0, tx},
          {31'd0, e});
      if (k == 40) begin
        rd(12'd1, v); chk("w55_stop_busy", v, 32'h05);
      end
    end
    rd(12'd1, v); chk("w55_done", v, 32'h04);

    // DIV=2, fill FIFO, overflow, clear.
    cyc(12'd2, 1'b1, 32'd2);
    txlog.delete();
    logon = 1'b1;
    cyc(12'd0, 1'b1, 32'hA1);
    cyc(12'd0, 1'b1, 32'hB2);
    cyc(12'd0, 1'b1, 32'hC3);
    cyc(12'd0, 1'b1, 32'hD4);
    cyc(12'd0, 1'b1, 32'hE5);
    rd(12'd1, v); chk("fill_status", v, 32'h43);
    cyc(12'd0, 1'b1, 32'hF6);
    rd(12'd1, v); chk("ovf_set", v, 32'h4B);
    cyc(12'd1, 1'b1, 32'd0);
    rd(12'd1, v); chk("ovf_clr", v, 32'h43);
    drain("fill_drain", 300);
    idle(2);
    logon = 1'b0;
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2;
    exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
    exp_b[4] = 8'hE5;
    j = 0;
    pj = -1;
    for (int f = 0; f < 5; f++) begin
      j = find0(j);
      if (j < 0 || j + 19 >= txlog.size()) begin
        chk($sformatf("frame%0d_found", f), 32'd0, 32'd1);
        break;
      end
      for (int i = 0; i < 8; i++) pat[i] = txlog[j+2+2*i];
      chk($sformatf("frame%0d_byte", f), {24'd0, pat},
          {24'd0, exp_b[f]});
      if (pj >= 0)
        chk($sformatf("frame%0d_gap", f), j - pj, 32'd21);
      pj = j;
      j = j + 20;
    end
    rd(12'd1, v); chk("fill_end", v, 32'h04);

    // DIV=0 behaves as 1.
    cyc(12'd2, 1'b1, 32'd0);
    rd(12'd2, v); chk("div0_read", v, 32'd0);
    cyc(12'd0, 1'b1, 32'hFF);
    for (int k = 1; k <= 11; k++) begin
      idle(1);
      chk($sformatf("ff_tx%0d", k), {31'd0, tx},
          (k == 1) ? 32'd0 : 32'd1);
      if (k == 10) begin
        rd(12'd1, v); chk("ff_stop", v, 32'h05);
      end
    end
    rd(12'd1, v); chk("ff_done", v, 32'h04);

    // Reset mid-frame with bytes queued.
    cyc(12'd2, 1'b1, 32'd4);
    cyc(12'd0, 1'b1, 32'h0F);
    cyc(12'd0, 1'b1, 32'h11);
    cyc(12'd0, 1'b1, 32'h22);
    idle(16);
    rd(12'd1, v); chk("mid_status", v, 32'h21);
    pulse_rst();
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    rd(12'd1, v); chk("mid_rst_status", v, 32'h04);
    rd(12'd2, v); chk("mid_rst_div", v, 32'd868);
    idle(60);
    rd(12'd1, v); chk("mid_quiet", v, 32'h04);

    // Address decode.
    rd(12'd0, v); chk("rd_a0", v, 32'd0);
    rd(12'd3, v); chk("rd_a3", v, 32'd0);
    cyc(12'd3, 1'b1, 32'hFFFF_FFFF);
    rd(12'd1, v); chk("a3_status", v, 32'h04);
    rd(12'd2, v); chk("a3_div", v, 32'd868);
    rd(12'h801, v); chk("rd_801", v, 32'h04);
    cyc(12'h802, 1'b1, 32'hABCD_0003);
    rd(12'd2, v); chk("wr_802", v, 32'd3);

    // Random traffic checked by the per-cycle model.
    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        cyc({$urandom_range(0, 15), 8'd0}, 1'b1, $urandom);
      end else if (r < 39) begin
        cyc(12'd1, 1'b1, $urandom);
      end else if (r < 45) begin
        if (!m_busy()) begin
          v = $urandom;
          v[15:0] = 16'($urandom_range(0, 3));
          cyc(12'd2, 1'b1, v);
        end else begin
          idle(1);
        end
      end else if (r < 48) begin
        cyc(12'd3, 1'b1, $urandom);
      end else if (r == 48) begin
        pulse_rst();
        cyc(12'd2, 1'b1, 32'd1);
      end else begin
        drive(12'($urandom), 1'b0, 1'($urandom), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    drive(12'd1, 1'b0, 1'b0, 32'd0);
    drain("rand_drain", 2000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/xuart_tx.md
# xuart_tx

Memory-mapped UART transmitter hanging on the processor's external parallel interface (par_addr/par_we/par_re/par_out/par_in). Software writes bytes into a small TX FIFO, and a bit-timing state machine serialises them as 8N1 frames on a single output pin. It is the first user peripheral downstream of the core's external port and replaces the simulation-only character printer for on-board console output.

## Interface
- DATA_W, 32, data bus width (matches core data width)
- PAR_ADDR_W, 12, width of par_addr (core ADDR_W-1); only bits [1:0] decoded
- FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2)
- DIV_RST, 16'd868, baud divisor reset value (clock cycles per bit)
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- par_addr  in  PAR_ADDR_W  register address; [1:0] used, upper bits ignored
- par_re  in  1  read strobe
- par_we  in  1  write strobe
- par_out  in  DATA_W  write data from core
- par_in  out  DATA_W  read data to core, combinational from par_addr
- tx  out  1  serial line, idle high

## Operation
- Register map (par_addr[1:0]):
  - 0 TXDATA: write pushes par_out[7:0] into FIFO; reads 0
  - 1 STATUS (read): [0] busy, [1] full, [2] empty, [3] overflow (sticky), [6:4] count, others 0; any write clears overflow
  - 2 DIV: rw, [15:0] divisor; upper bits read 0
  - 3: reads 0, writes ignored
- busy = (state != IDLE) | ~empty.
- Push to full FIFO is dropped and sets overflow, unless a pop happens in the same cycle, in which case the push is accepted and count stays unchanged.
- Effective divisor = max(DIV, 1); DIV=0 behaves as 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1; if FIFO non-empty, pop head into shift register, load bit counter, go START.
  - START: tx=0 for div cycles, then go DATA.
  - DATA: 8 bits LSB first, each held for div cycles, then go STOP.
  - STOP: tx=1 for div cycles, then go IDLE.
- DIV is sampled at each bit boundary. A DIV write mid-frame takes effect from the next bit.
- par_re has no side effects; par_in is valid in the same cycle as par_addr.

## Timing
- Reset values: tx=1, state IDLE, FIFO empty (count 0), overflow 0, DIV=DIV_RST, par_in follows address (STATUS reads 0x04 after reset).
- Write to TXDATA at edge E0: FIFO count updates after E0.
- At edge E1, FSM pops the byte; tx falls to 0 after E1. Write-to-start-bit latency is 2 cycles.
- Frame length is 10·div cycles.
- Back-to-back frames have exactly 1 idle cycle (tx=1) between the end of STOP and the next START.
- Reset asserted mid-frame: on the next edge, tx=1, FIFO flushed, and all state returns to reset values. No partial frame completes.
- Write to TXDATA and pop in the same cycle with FIFO empty is impossible: FSM pops only the registered contents.

## Test plan
- Reset: hold rst 2 cycles → tx=1, STATUS=0x04, DIV reads 868.
- DIV=4, write 0x55 → tx low 2 cycles after write, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles. Total frame 40 cycles, busy clears the cycle after STOP ends.
- DIV=2, write 0xA1,0xB2,0xC3,0xD4,0xE5 in consecutive cycles → first byte popped on the 2nd cycle, so 5th write accepted with count=4 and overflow=0. Then write 0xF6 before the next pop → dropped, overflow=1. Write STATUS → overflow=0. All 5 accepted bytes appear in order with 1-cycle gaps.
- DIV=0 → each bit lasts 1 cycle. Frame for 0xFF is 10 cycles (start low 1 cycle, 9 high).
- Reset mid-DATA bit 3 of 0x0F with 2 bytes queued → tx=1 next cycle, STATUS=0x04, no further frames.
- Reads of addr 0 and addr 3 return 0. Write to addr 3 changes nothing. Upper par_addr bits set (0x801 reads STATUS).
